// File: rtl/acq_udp_framer_pkg.sv
// acq_udp_framer_pkg
// Shared definitions for the acquisition UDP framer and for anything that
// decodes its TX status words: the FSM encoding, payload geometry and the bit
// positions of the fields inside the 96-bit status word.
package acq_udp_framer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StLoad,
        StBytes,
        StStatus
    } state_e;

    // 108-bit word padded to 112 bits and sent as 14 bytes
    localparam int unsigned BYTES_PER_WORD = 14;
    // 16-bit sequence number at the front of each payload
    localparam int unsigned HDR_BYTES      = 2;

    // Status word layout: {dest_mac, dest_ip, payload_len}
    localparam int unsigned STATUS_MAC_MSB = 95;
    localparam int unsigned STATUS_MAC_LSB = 48;
    localparam int unsigned STATUS_IP_MSB  = 47;
    localparam int unsigned STATUS_IP_LSB  = 16;
    localparam int unsigned STATUS_LEN_MSB = 15;
    localparam int unsigned STATUS_LEN_LSB = 0;

    // UDP payload length for a packet holding 'words' acquisition words
    function automatic logic [15:0] payload_len(input logic [7:0] words);
        return 16'(HDR_BYTES) + 16'(BYTES_PER_WORD) * {8'd0, words};
    endfunction

endpackage

// File: rtl/acq_udp_framer.sv
// acq_udp_framer
// Packs 108-bit words from a show-ahead acquisition FIFO into UDP payloads
// for the TX FIFO pair of the 1 Gb Ethernet core. Each payload is a 16-bit
// sequence number followed by up to WORDS_PER_PKT words, 14 bytes each,
// MSB-first. A partial packet is closed after TIMEOUT empty cycles, or after
// the word in flight when enable drops.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   enable                streaming enable
//   dest_mac, dest_ip     destination, latched when a packet starts
//   acq_rdreq/rddata/rdempty   show-ahead acquisition FIFO read side
//   tx_fifo_data/_write/_full          payload byte FIFO
//   tx_fifo_status/_write/_full        per-packet status FIFO
//   busy                  packet in progress
//   seq_num               sequence number of the next packet
module acq_udp_framer
    import acq_udp_framer_pkg::*;
#(
    parameter int unsigned WORDS_PER_PKT = 64,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [47:0]  dest_mac,
    input  logic [31:0]  dest_ip,
    output logic         acq_rdreq,
    input  logic [107:0] acq_rddata,
    input  logic         acq_rdempty,
    output logic [7:0]   tx_fifo_data,
    output logic         tx_fifo_data_write,
    input  logic         tx_fifo_data_full,
    output logic [95:0]  tx_fifo_status,
    output logic         tx_fifo_status_write,
    input  logic         tx_fifo_status_full,
    output logic         busy,
    output logic [15:0]  seq_num
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [15:0]         seq_q, seq_d;
    logic [7:0]          word_cnt_q, word_cnt_d;
    logic [3:0]          byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [111:0]        shreg_q, shreg_d;
    logic [47:0]         mac_q, mac_d;
    logic [31:0]         ip_q, ip_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            seq_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            shreg_q    <= '0;
            mac_q      <= '0;
            ip_q       <= '0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            shreg_q    <= shreg_d;
            mac_q      <= mac_d;
            ip_q       <= ip_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        seq_d                = seq_q;
        word_cnt_d           = word_cnt_q;
        byte_cnt_d           = byte_cnt_q;
        idle_cnt_d           = idle_cnt_q;
        shreg_d              = shreg_q;
        mac_d                = mac_q;
        ip_d                 = ip_q;
        acq_rdreq            = 1'b0;
        tx_fifo_data         = 8'd0;
        tx_fifo_data_write   = 1'b0;
        tx_fifo_status       = 96'd0;
        tx_fifo_status_write = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!enable) begin
                    seq_d = 16'd0;
                end else if (!acq_rdempty && !tx_fifo_status_full) begin
                    // Status room is reserved up front so the packet can always close
                    mac_d      = dest_mac;
                    ip_d       = dest_ip;
                    word_cnt_d = 8'd0;
                    idle_cnt_d = '0;
                    state_d    = StHdrHi;
                end
            end

            StHdrHi: begin
                tx_fifo_data       = seq_q[15:8];
                tx_fifo_data_write = !tx_fifo_data_full;
                if (!tx_fifo_data_full) begin
                    state_d = StHdrLo;
                end
            end

            StHdrLo: begin
                tx_fifo_data       = seq_q[7:0];
                tx_fifo_data_write = !tx_fifo_data_full;
                if (!tx_fifo_data_full) begin
                    state_d = StLoad;
                end
            end

            StLoad: begin
                if (!enable) begin
                    // No word in flight: close what we have
                    state_d = StStatus;
                end else if (!acq_rdempty) begin
                    acq_rdreq  = 1'b1;
                    shreg_d    = {4'b0000, acq_rddata};
                    idle_cnt_d = '0;
                    byte_cnt_d = 4'd0;
                    state_d    = StBytes;
                end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
                    state_d = StStatus;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end

            StBytes: begin
                tx_fifo_data       = shreg_q[111:104];
                tx_fifo_data_write = !tx_fifo_data_full;
                if (!tx_fifo_data_full) begin
                    shreg_d    = {shreg_q[103:0], 8'd0};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'(BYTES_PER_WORD - 1)) begin
                        word_cnt_d = word_cnt_q + 8'd1;
                        if ((word_cnt_q + 8'd1 == 8'(WORDS_PER_PKT)) || !enable) begin
                            state_d = StStatus;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end
            end

            StStatus: begin
                tx_fifo_status[STATUS_MAC_MSB:STATUS_MAC_LSB] = mac_q;
                tx_fifo_status[STATUS_IP_MSB:STATUS_IP_LSB]   = ip_q;
                tx_fifo_status[STATUS_LEN_MSB:STATUS_LEN_LSB] = payload_len(word_cnt_q);
                tx_fifo_status_write = !tx_fifo_status_full;
                if (!tx_fifo_status_full) begin
                    seq_d   = seq_q + 16'd1;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign seq_num = seq_q;

endmodule
